// File: rtl/alu_seq_pkg.sv
// Shared types and field layout for the ALU command sequencer.
// Field offsets are functions of the operand and hold widths.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SHIFT = 2'b01;
  localparam logic [1:0] OP_COUNT = 2'b10;
  localparam logic [1:0] OP_LOGIC = 2'b11;

  // cmd_data = {hold, cin, o[1:0], s[2:0], b, a}
  function automatic int b_lsb(input int w);
    return w;
  endfunction

  function automatic int s_lsb(input int w);
    return 2 * w;
  endfunction

  function automatic int o_lsb(input int w);
    return 2 * w + 3;
  endfunction

  function automatic int cin_bit(input int w);
    return 2 * w + 5;
  endfunction

  function automatic int hold_lsb(input int w);
    return 2 * w + 6;
  endfunction

  function automatic int cmd_width(input int w, input int hw);
    return 2 * w + hw + 6;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle between host and sequencer.
// The host side is the master, the sequencer the slave.
interface alu_cmd_sequencer_if #(
  parameter int W      = 8,
  parameter int HOLD_W = 4
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2*W+HOLD_W+5:0]  cmd_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [W-1:0]           res_data;
  logic                   res_carry;
  logic [1:0]             res_op;

  modport master (
    output cmd_valid, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_carry, res_op
  );

  modport slave (
    input  cmd_valid, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_carry, res_op
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
// Full/empty come from the count only; a push is refused when full.
module alu_cmd_fifo #(
  parameter int DW    = 26,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives the ALU pins for hold+1 cycles,
// captures F/C2 and returns each result over valid/ready.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W      = 8,
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_cmd_sequencer_if.slave bus,
  output logic              busy,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [2:0]        alu_s,
  output logic [1:0]        alu_o,
  output logic              alu_c1,
  output logic              alu_g,
  input  logic [W-1:0]      alu_f,
  input  logic              alu_c2
);
  localparam int CMD_W    = cmd_width(W, HOLD_W);
  localparam int B_LSB    = b_lsb(W);
  localparam int S_LSB    = s_lsb(W);
  localparam int O_LSB    = o_lsb(W);
  localparam int CIN_BIT  = cin_bit(W);
  localparam int HOLD_LSB = hold_lsb(W);

  state_t              state;
  state_t              next_state;
  logic [CMD_W-1:0]    head;
  logic                full;
  logic                empty;
  logic                pop;
  logic [HOLD_LSB-1:0] cmd_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                res_hs;

  logic [W-1:0]        a_d;
  logic [W-1:0]        b_d;
  logic [2:0]          s_d;
  logic [1:0]          o_d;
  logic                c1_d;
  logic                g_d;
  logic                rv_d;
  logic [W-1:0]        rd_d;
  logic                rc_d;
  logic [1:0]          ro_d;

  alu_cmd_fifo #(
    .DW    (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.cmd_valid),
    .pop   (pop),
    .wdata (bus.cmd_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.cmd_ready = !full;
  assign pop    = (state == S_IDLE) && !empty;
  assign res_hs = bus.res_valid && bus.res_ready;
  assign busy   = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cmd_q    <= '0;
      hold_cnt <= '0;
    end else begin
      state <= next_state;
      if (pop) begin
        cmd_q    <= head[HOLD_LSB-1:0];
        hold_cnt <= head[HOLD_LSB +: HOLD_W];
      end else if (state == S_DRIVE && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:    if (!empty) next_state = S_DRIVE;
      S_DRIVE:   if (hold_cnt == '0) next_state = S_CAPTURE;
      S_CAPTURE: next_state = S_RESP;
      S_RESP:    if (res_hs) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Pins are registered from the current state, so the enable window
  // trails the DRIVE state by one clock and spans CAPTURE.
  always_comb begin
    a_d  = alu_a;
    b_d  = alu_b;
    s_d  = alu_s;
    o_d  = alu_o;
    c1_d = alu_c1;
    g_d  = 1'b1;
    rv_d = 1'b0;
    rd_d = bus.res_data;
    rc_d = bus.res_carry;
    ro_d = bus.res_op;
    unique case (state)
      S_DRIVE: begin
        a_d  = cmd_q[0 +: W];
        b_d  = cmd_q[B_LSB +: W];
        s_d  = cmd_q[S_LSB +: 3];
        o_d  = cmd_q[O_LSB +: 2];
        c1_d = cmd_q[CIN_BIT];
        g_d  = 1'b0;
      end
      S_CAPTURE: begin
        rd_d = alu_f;
        rc_d = alu_c2;
        ro_d = cmd_q[O_LSB +: 2];
      end
      S_RESP:  rv_d = !res_hs;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_s         <= '0;
      alu_o         <= '0;
      alu_c1        <= 1'b0;
      alu_g         <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_carry <= 1'b0;
      bus.res_op    <= '0;
    end else begin
      alu_a         <= a_d;
      alu_b         <= b_d;
      alu_s         <= s_d;
      alu_o         <= o_d;
      alu_c1        <= c1_d;
      alu_g         <= g_d;
      bus.res_valid <= rv_d;
      bus.res_data  <= rd_d;
      bus.res_carry <= rc_d;
      bus.res_op    <= ro_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and random checks of alu_cmd_sequencer against a
// behavioural ALU and an in-order expected-result queue.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int W      = 8;
  localparam int DEPTH  = 4;
  localparam int HOLD_W = 4;
  localparam int CW     = 2*W + HOLD_W + 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         busy;
  logic [W-1:0] alu_a, alu_b, alu_f;
  logic [2:0]   alu_s;
  logic [1:0]   alu_o;
  logic         alu_c1, alu_g, alu_c2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W+2:0] exp_q[$];

  alu_cmd_sequencer_if #(.W(W), .HOLD_W(HOLD_W)) bus ();

  alu_cmd_sequencer #(.W(W), .DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_s  (alu_s),
    .alu_o  (alu_o),
    .alu_c1 (alu_c1),
    .alu_g  (alu_g),
    .alu_f  (alu_f),
    .alu_c2 (alu_c2)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_alu(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic [2:0] s, input logic [1:0] o, input logic c);
    logic [W-1:0] r;
    case (o)
      OP_ADD:   return {1'b0, a} + {1'b0, b} + (W+1)'(c);
      OP_SHIFT: return {a, c};
      OP_COUNT: return {1'b0, b} + (W+1)'(1);
      default: begin
        case (s)
          3'd0:    r = a & b;
          3'd1:    r = a | b;
          3'd2:    r = a ^ b;
          3'd3:    r = ~(a & b);
          3'd4:    r = ~(a | b);
          3'd5:    r = ~(a ^ b);
          3'd6:    r = ~a;
          default: r = a;
        endcase
        return {1'b0, r};
      end
    endcase
  endfunction

  always_comb begin
    if (alu_g) {alu_c2, alu_f} = {1'b1, 8'h5A};
    else {alu_c2, alu_f} = ref_alu(alu_a, alu_b, alu_s, alu_o, alu_c1);
  end

  function automatic logic [CW-1:0] mk(
    input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
    input logic [1:0] o, input logic cin, input logic [HOLD_W-1:0] h);
    return {h, cin, o, s, b, a};
  endfunction

  function automatic logic [CW-1:0] rand_cmd(input int hmax);
    return mk(W'($urandom), W'($urandom), 3'($urandom), 2'($urandom),
              1'($urandom), HOLD_W'($urandom_range(0, hmax)));
  endfunction

  function automatic logic [W+2:0] expect_of(input logic [CW-1:0] c);
    return {c[2*W+4:2*W+3],
            ref_alu(c[W-1:0], c[2*W-1:W], c[2*W+2:2*W], c[2*W+4:2*W+3], c[2*W+5])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [CW-1:0] c, output bit acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = c;
    acc = bus.cmd_ready;
    tick();
    bus.cmd_valid = 1'b0;
    if (acc) exp_q.push_back(expect_of(c));
  endtask

  task automatic check_res(input string tag);
    logic [W+2:0] e;
    chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    chk({tag, "_queue"}, 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk({tag, "_data"},  32'(bus.res_data),  32'(e[W-1:0]));
    chk({tag, "_carry"}, 32'(bus.res_carry), 32'(e[W]));
    chk({tag, "_op"},    32'(bus.res_op),    32'(e[W+2:W+1]));
    tick();
  endtask

  task automatic run_one(input logic [CW-1:0] c, output logic [W-1:0] d,
                         output logic cy);
    bit acc;
    int cyc, glow, opbad, h;
    h = int'(c[CW-1 -: HOLD_W]);
    offer(c, acc);
    chk("accept", 32'(acc), 32'd1);
    cyc = 0; glow = 0; opbad = 0;
    while (!bus.res_valid && cyc < 40) begin
      tick();
      cyc++;
      if (!alu_g) begin
        glow++;
        if ({alu_c1, alu_o, alu_s, alu_b, alu_a} !== c[2*W+5:0]) opbad++;
      end
    end
    chk("latency", 32'(cyc), 32'(h + 4));
    chk("g_low", 32'(glow), 32'(h + 1));
    chk("operands", 32'(opbad), 32'd0);
    d  = bus.res_data;
    cy = bus.res_carry;
    check_res("res");
  endtask

  initial begin
    logic [W-1:0] d;
    logic cy;
    bit acc;
    int nacc, n, seen;

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.res_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_alu_g", 32'(alu_g), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    rst = 1'b0;
    tick();

    run_one(mk(8'h3C, 8'h0F, 3'd0, OP_ADD, 1'b1, 4'd0), d, cy);
    chk("add_data", 32'(d), 32'h4C);
    chk("add_carry", 32'(cy), 32'd0);

    run_one(mk(8'hFF, 8'h01, 3'd0, OP_ADD, 1'b0, 4'd0), d, cy);
    chk("carry_data", 32'(d), 32'h00);
    chk("carry_carry", 32'(cy), 32'd1);

    run_one(mk(8'h81, 8'h00, 3'd0, OP_SHIFT, 1'b1, 4'd3), d, cy);
    run_one(mk(8'h55, 8'hFF, 3'd2, OP_LOGIC, 1'b0, 4'd15), d, cy);

    for (int i = 0; i < 10; i++) run_one(rand_cmd(15), d, cy);

    bus.res_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 7; i++) begin
      offer(rand_cmd(2), acc);
      if (acc) nacc++;
    end
    chk("bp_accepted", 32'(nacc), 32'd5);
    chk("bp_ready_low", 32'(bus.cmd_ready), 32'd0);
    repeat (12) tick();
    chk("bp_valid_held", 32'(bus.res_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!bus.res_valid && n < 40) begin
        tick();
        n++;
      end
      check_res("bp");
    end
    tick();
    chk("bp_ready_back", 32'(bus.cmd_ready), 32'd1);
    chk("bp_busy_idle", 32'(busy), 32'd0);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    offer(mk(8'h11, 8'h22, 3'd0, OP_ADD, 1'b0, 4'd5), acc);
    chk("mid_accept", 32'(acc), 32'd1);
    n = 0;
    while (alu_g && n < 10) begin
      tick();
      n++;
    end
    chk("mid_drive_seen", 32'(alu_g), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_alu_g", 32'(alu_g), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_res_valid", 32'(bus.res_valid), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    seen = 0;
    repeat (30) begin
      tick();
      if (bus.res_valid) seen++;
    end
    chk("mid_no_result", 32'(seen), 32'd0);

    run_one(mk(8'h10, 8'h20, 3'd0, OP_ADD, 1'b1, 4'd1), d, cy);
    chk("post_rst_data", 32'(d), 32'h31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
